// File: rtl/cpu_run_ctrl_if.sv
// Button/halt inputs and CPU enable/reset outputs shared between the
// board-side source (master) and the run controller (slave).
interface cpu_run_ctrl_if;
    logic        btn_step;
    logic        btn_run;
    logic        btn_cpurst;
    logic        halt_req;
    logic        cpu_en;
    logic        cpu_rst;
    logic [1:0]  state;
    logic [15:0] step_cnt;

    modport master (
        output btn_step, btn_run, btn_cpurst, halt_req,
        input  cpu_en, cpu_rst, state, step_cnt
    );

    modport slave (
        input  btn_step, btn_run, btn_cpurst, halt_req,
        output cpu_en, cpu_rst, state, step_cnt
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// RCPU execution controller: turns debounced button levels into single-step,
// free-run clock enables and a timed CPU reset pulse.
//
// state | meaning
// HALT  | CPU stopped, waiting for a step or run press
// STEP  | one-cycle cpu_en pulse, then back to HALT
// RUN   | cpu_en pulse every RUN_DIV cycles until run press or halt_req
// RESET | cpu_rst held for RST_CYCLES cycles, step_cnt cleared
module cpu_run_ctrl #(
    parameter int RUN_DIV    = 25_000_000,
    parameter int RST_CYCLES = 4
) (
    input  logic            clk_100MHz,
    input  logic            rst,
    cpu_run_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_STEP  = 2'd1,
        ST_RUN   = 2'd2,
        ST_RESET = 2'd3
    } state_t;

    localparam logic [26:0] DIV_LAST = 27'(RUN_DIV - 1);
    localparam logic [7:0]  RST_LAST = 8'(RST_CYCLES - 1);

    state_t      state_q;
    logic        cpu_en_q;
    logic        cpu_rst_q;
    logic [15:0] step_cnt_q;
    logic [26:0] div_cnt;
    logic [7:0]  rst_cnt;
    logic        prev_step;
    logic        prev_run;
    logic        prev_cpurst;

    logic step_rise;
    logic run_rise;
    logic cpurst_rise;

    assign step_rise   = bus.btn_step   & ~prev_step;
    assign run_rise    = bus.btn_run    & ~prev_run;
    assign cpurst_rise = bus.btn_cpurst & ~prev_cpurst;

    always_ff @(posedge clk_100MHz) begin
        // prev tracks the buttons during reset so a held button gives no edge
        prev_step   <= bus.btn_step;
        prev_run    <= bus.btn_run;
        prev_cpurst <= bus.btn_cpurst;
        if (rst) begin
            state_q    <= ST_RESET;
            cpu_en_q   <= 1'b0;
            cpu_rst_q  <= 1'b1;
            step_cnt_q <= 16'd0;
            div_cnt    <= 27'd0;
            rst_cnt    <= 8'd0;
        end else begin
            cpu_en_q <= 1'b0;
            if (cpurst_rise) begin
                state_q    <= ST_RESET;
                rst_cnt    <= 8'd0;
                cpu_rst_q  <= 1'b1;
                step_cnt_q <= 16'd0;
            end else begin
                case (state_q)
                    ST_RESET: begin
                        step_cnt_q <= 16'd0;
                        if (rst_cnt == RST_LAST) begin
                            state_q   <= ST_HALT;
                            cpu_rst_q <= 1'b0;
                        end else begin
                            rst_cnt   <= rst_cnt + 8'd1;
                            cpu_rst_q <= 1'b1;
                        end
                    end
                    ST_HALT: begin
                        if (run_rise) begin
                            state_q <= ST_RUN;
                            div_cnt <= 27'd0;
                        end else if (step_rise) begin
                            state_q    <= ST_STEP;
                            cpu_en_q   <= 1'b1;
                            step_cnt_q <= step_cnt_q + 16'd1;
                        end
                    end
                    ST_STEP: begin
                        state_q <= ST_HALT;
                    end
                    ST_RUN: begin
                        // leaving RUN wins over a pulse due on the same edge
                        if (run_rise || bus.halt_req) begin
                            state_q <= ST_HALT;
                        end else if (div_cnt == DIV_LAST) begin
                            div_cnt    <= 27'd0;
                            cpu_en_q   <= 1'b1;
                            step_cnt_q <= step_cnt_q + 16'd1;
                        end else begin
                            div_cnt <= div_cnt + 27'd1;
                        end
                    end
                    default: state_q <= ST_RESET;
                endcase
            end
        end
    end

    assign bus.cpu_en   = cpu_en_q;
    assign bus.cpu_rst  = cpu_rst_q;
    assign bus.state    = state_q;
    assign bus.step_cnt = step_cnt_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl (RUN_DIV=5, RST_CYCLES=4): each cycle pushes
// the expected outputs, advances one edge and pops/compares them.
module tb_cpu_run_ctrl;
    localparam logic [1:0] HALT  = 2'd0;
    localparam logic [1:0] STEP  = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] RESET = 2'd3;

    typedef struct {
        string       tag;
        logic [19:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    cpu_run_ctrl_if bus ();

    cpu_run_ctrl #(.RUN_DIV(5), .RST_CYCLES(4)) dut (
        .clk_100MHz (clk),
        .rst        (rst),
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic cyc(input string tag, input logic [1:0] st, input logic en,
                       input logic rs, input logic [15:0] cnt);
        exp_t        e;
        logic [19:0] obs;
        e.tag = tag;
        e.v   = {st, en, rs, cnt};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e   = sb.pop_front();
        obs = {bus.state, bus.cpu_en, bus.cpu_rst, bus.step_cnt};
        total++;
        assert (obs === e.v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h (state,en,rst,cnt)", e.tag, obs, e.v);
        end
    endtask

    task automatic run_quiet(input string tag, input int n, input logic [15:0] cnt);
        for (int i = 0; i < n; i++) cyc(tag, RUN, 1'b0, 1'b0, cnt);
    endtask

    initial begin
        bus.btn_step   = 1'b0;
        bus.btn_run    = 1'b0;
        bus.btn_cpurst = 1'b0;
        bus.halt_req   = 1'b0;

        // 1: reset and power-up
        for (int i = 0; i < 3; i++) cyc("in_rst", RESET, 1'b0, 1'b1, 16'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cyc("rst_hold", RESET, 1'b0, 1'b1, 16'd0);
        cyc("rst_done", HALT, 1'b0, 1'b0, 16'd0);
        cyc("halt_idle", HALT, 1'b0, 1'b0, 16'd0);

        // 2: single step, held button, second press
        bus.btn_step = 1'b1;
        cyc("step1", STEP, 1'b1, 1'b0, 16'd1);
        for (int i = 0; i < 9; i++) cyc("step1_held", HALT, 1'b0, 1'b0, 16'd1);
        bus.btn_step = 1'b0;
        cyc("step1_rel", HALT, 1'b0, 1'b0, 16'd1);
        bus.btn_step = 1'b1;
        cyc("step2", STEP, 1'b1, 1'b0, 16'd2);
        cyc("step2_back", HALT, 1'b0, 1'b0, 16'd2);
        bus.btn_step = 1'b0;
        cyc("step2_rel", HALT, 1'b0, 1'b0, 16'd2);

        // 3: free run, three pulses, halt on a due pulse
        bus.btn_run = 1'b1;
        cyc("run_enter", RUN, 1'b0, 1'b0, 16'd2);
        bus.btn_run = 1'b0;
        for (int p = 1; p <= 3; p++) begin
            run_quiet("run_gap", 4, 16'(1 + p));
            cyc("run_pulse", RUN, 1'b1, 1'b0, 16'(2 + p));
        end
        run_quiet("run_gap", 4, 16'd5);
        bus.btn_run = 1'b1;
        cyc("run_stop_due", HALT, 1'b0, 1'b0, 16'd5);
        bus.btn_run = 1'b0;
        cyc("run_stopped", HALT, 1'b0, 1'b0, 16'd5);

        // 4: halt_req on the due cycle; step ignored in RUN
        bus.btn_run = 1'b1;
        cyc("run2_enter", RUN, 1'b0, 1'b0, 16'd5);
        bus.btn_run  = 1'b0;
        bus.btn_step = 1'b1;
        cyc("run2_step_ign", RUN, 1'b0, 1'b0, 16'd5);
        bus.btn_step = 1'b0;
        run_quiet("run2_gap", 3, 16'd5);
        bus.halt_req = 1'b1;
        cyc("halt_req_due", HALT, 1'b0, 1'b0, 16'd5);
        cyc("halt_req_in_halt", HALT, 1'b0, 1'b0, 16'd5);
        bus.halt_req = 1'b0;

        // 5: simultaneous edges from RUN with step_cnt=7
        bus.btn_run = 1'b1;
        cyc("run3_enter", RUN, 1'b0, 1'b0, 16'd5);
        bus.btn_run = 1'b0;
        run_quiet("run3_gap", 4, 16'd5);
        cyc("run3_pulse", RUN, 1'b1, 1'b0, 16'd6);
        run_quiet("run3_gap", 4, 16'd6);
        cyc("run3_pulse", RUN, 1'b1, 1'b0, 16'd7);
        run_quiet("run3_gap", 1, 16'd7);
        bus.btn_cpurst = 1'b1;
        bus.btn_run    = 1'b1;
        bus.btn_step   = 1'b1;
        cyc("all_edges", RESET, 1'b0, 1'b1, 16'd0);
        for (int i = 0; i < 3; i++) cyc("cpurst_hold", RESET, 1'b0, 1'b1, 16'd0);
        cyc("cpurst_done", HALT, 1'b0, 1'b0, 16'd0);
        cyc("btns_held", HALT, 1'b0, 1'b0, 16'd0);
        bus.btn_cpurst = 1'b0;
        bus.btn_run    = 1'b0;
        bus.btn_step   = 1'b0;
        cyc("btns_rel", HALT, 1'b0, 1'b0, 16'd0);

        // 6a: step_cnt wrap from a forced 0xFFFF
        @(negedge clk);
        force dut.step_cnt_q = 16'hFFFF;
        cyc("preload", HALT, 1'b0, 1'b0, 16'hFFFF);
        release dut.step_cnt_q;
        bus.btn_step = 1'b1;
        cyc("wrap_step", STEP, 1'b1, 1'b0, 16'h0000);
        bus.btn_step = 1'b0;
        cyc("wrap_back", HALT, 1'b0, 1'b0, 16'h0000);

        // 6b: rst mid-RUN on a due pulse, step button held through reset
        bus.btn_run = 1'b1;
        cyc("run4_enter", RUN, 1'b0, 1'b0, 16'd0);
        bus.btn_run = 1'b0;
        run_quiet("run4_gap", 4, 16'd0);
        rst          = 1'b1;
        bus.btn_step = 1'b1;
        cyc("rst_mid_run", RESET, 1'b0, 1'b1, 16'd0);
        cyc("rst_held", RESET, 1'b0, 1'b1, 16'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cyc("rst2_hold", RESET, 1'b0, 1'b1, 16'd0);
        cyc("rst2_done", HALT, 1'b0, 1'b0, 16'd0);
        cyc("held_no_step", HALT, 1'b0, 1'b0, 16'd0);
        cyc("held_no_step", HALT, 1'b0, 1'b0, 16'd0);
        bus.btn_step = 1'b0;
        cyc("held_rel", HALT, 1'b0, 1'b0, 16'd0);
        bus.btn_step = 1'b1;
        cyc("repress", STEP, 1'b1, 1'b0, 16'd1);
        bus.btn_step = 1'b0;
        cyc("repress_back", HALT, 1'b0, 1'b0, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
